// File: rtl/tag_bank_nway.sv
// tag_bank_nway: N-way set-associative tag bank with all-way compare, victim choice and flush.
// Latency: lookup response registered 1 cycle after acceptance; fills visible at the next edge.
// Backpressure: lkp_ready low while flushing or in reset; responses have no backpressure.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   lkp_valid/lkp_ready/lkp_idx/tag lookup request handshake
//   rsp_valid/rsp_hit/rsp_way       one-cycle lookup response (hit way, or victim way on miss)
//   fill_valid/fill_idx/way/tag     tag write into a set/way (IDLE only)
//   flush_req/flush_busy            invalidate all sets, one set per cycle
//   hit_cnt/miss_cnt                saturating statistics counters
// Optional feature macro: TAG_BANK_STATS_EN (hit/miss counters; tied to 0 when undefined).

module tag_bank_nway #(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 16,
  parameter  int TAG_W = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lkp_valid,
  output logic             lkp_ready,
  input  logic [IDX_W-1:0] lkp_idx,
  input  logic [TAG_W-1:0] lkp_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] flush_cnt, flush_cnt_nxt;
  logic             in_idle;
  logic             flushing;

  // Storage: tags are never reset, valid bits and victim pointers are.
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAY_W-1:0] rr_ptr    [SETS];

  logic             lkp_acc;
  logic             fill_en;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] rsp_way_nxt;

  // ---------------------------------------------------------------------------
  // Flush sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    in_idle       = 1'b0;
    flushing      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_idle = 1'b1;
        if (flush_req) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      ST_FLUSH: begin
        // flush_req is ignored here; the sweep always runs to completion.
        flushing = 1'b1;
        if (flush_cnt == IDX_W'(SETS - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Gating with rst_n only affects the visible handshake; internal flops are
  // held in reset anyway, so the acceptance term does not need it.
  assign lkp_ready  = rst_n & in_idle;
  assign flush_busy = flushing;

  assign lkp_acc = lkp_valid & in_idle;
  // A flush request in the same cycle wins over a fill.
  assign fill_en = fill_valid & in_idle & ~flush_req;

  // ---------------------------------------------------------------------------
  // All-way compare and victim selection (reads pre-fill contents)
  // ---------------------------------------------------------------------------
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    // Descending scan so the lowest-numbered way wins on multiple matches.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[lkp_idx][w] && (tag_mem[lkp_idx][w] == lkp_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_mem[lkp_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    rsp_way_nxt = rr_ptr[lkp_idx];
    if (hit) begin
      rsp_way_nxt = hit_way;
    end else if (inv_any) begin
      rsp_way_nxt = inv_way;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
    end else begin
      rsp_valid <= lkp_acc;
      rsp_hit   <= lkp_acc & hit;
      rsp_way   <= lkp_acc ? rsp_way_nxt : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State update: valid bits and round-robin victim pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else if (flushing) begin
      valid_mem[flush_cnt] <= '0;
      rr_ptr[flush_cnt]    <= '0;
    end else if (fill_en) begin
      valid_mem[fill_idx][fill_way] <= 1'b1;
      // WAYS is a power of two, so the natural WAY_W-bit wrap gives mod WAYS.
      rr_ptr[fill_idx] <= fill_way + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx][fill_way] <= fill_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit/miss statistics
  // ---------------------------------------------------------------------------
`ifdef TAG_BANK_STATS_EN
  logic        flush_start;
  logic [15:0] hit_q, miss_q;

  assign flush_start = in_idle & flush_req;

  // Clearing on flush start takes priority over counting a response that
  // completes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (flush_start) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rsp_valid) begin
      if (rsp_hit) begin
        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      end else begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
